game_auto_player: RTL and testbench
===================================

Name: game_auto_player

Overview:
Automatic initiator for the number-guessing game responder. It drives the guess and enter inputs and consumes the under/over/equal/update/remaining-attempts outputs. It runs a binary search over the guess range until the responder reports equal, attempts run out, or the responses become inconsistent. It sits beside the game block at top level and replaces the switch/key user for self-test and demo mode.

Parameters:
WIDTH, 8, guess width; search range 0..2^WIDTH-1
SETTLE_CYCLES, 1, cycles o_guess is held stable before o_enter pulses (min 1)
TIMEOUT_CYCLES, 255, max cycles waiting for i_update_leds (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse; begins a new search (ignored unless IDLE or DONE)
o_guess  out  WIDTH  guess presented to the responder
o_enter  out  1  one-cycle enter pulse to the responder
i_under  in  1  guess < secret (valid when i_update_leds=1)
i_over  in  1  guess > secret (valid when i_update_leds=1)
i_equal  in  1  guess == secret (valid when i_update_leds=1)
i_update_leds  in  1  one-cycle pulse; feedback for the last enter is valid this cycle
i_remaining_attempts  in  4  attempts left after the current guess (valid with i_update_leds)
o_busy  out  1  high from the cycle after i_start until DONE
o_done  out  1  high while in DONE
o_found  out  1  secret found; valid when o_done=1
o_error  out  1  inconsistent feedback or timeout; valid when o_done=1
o_num_guesses  out  4  enters issued in the current search, saturating at 15

Behaviour:
- Reset values: o_guess=0, o_enter=0, o_busy=0, o_done=0, o_found=0, o_error=0, o_num_guesses=0, lo=0, hi=2^WIDTH-1, state=IDLE.
- Search registers lo and hi are WIDTH+1 bits. mid=(lo+hi)>>1, computed on a WIDTH+1-bit sum with no overflow. o_guess=mid[WIDTH-1:0].
- States:
  - IDLE: wait for i_start.
  - SETUP: register o_guess=mid and hold it for SETTLE_CYCLES cycles.
  - ENTER: o_enter=1 for exactly one cycle; o_num_guesses increments (saturating).
  - WAIT: o_enter=0; o_guess stays stable; wait for i_update_leds.
  - EVAL: act on the feedback latched in the update cycle.
  - DONE: hold results.
- IDLE/DONE + i_start -> SETUP. On that transition: lo=0, hi=max, o_num_guesses=0, o_found=0, o_error=0, o_done=0.
- WAIT + i_update_leds -> EVAL. The flags and remaining attempts are captured in the same cycle.
- EVAL priority, first match wins:
  1. equal -> DONE, found=1.
  2. More than one of under/over/equal set, or none set -> DONE, error=1.
  3. remaining attempts == 0 -> DONE, found=0.
  4. under -> lo=mid+1; over -> hi=mid-1 (hi is a WIDTH+1-bit signed-safe compare; mid=0 with over gives hi<lo).
  5. Then if lo>hi -> DONE, error=1; otherwise -> SETUP.
- Latency per guess: SETTLE_CYCLES+1 (ENTER) + responder delay + 1 (EVAL).
- i_start outside IDLE/DONE is ignored. i_update_leds outside WAIT is ignored.
- Reset at any point, including mid-WAIT, returns to the reset values next cycle; no enter pulse is issued.
- WIDTH=8 worst case is 9 guesses.

Optional Feature:
GAME_AUTO_PLAYER_TIMEOUT_EN
- Defined: an 8-bit wait counter clears on entry to WAIT. If it reaches TIMEOUT_CYCLES without i_update_leds -> DONE, error=1, found=0.
- Undefined: no counter; WAIT holds indefinitely until i_update_leds or reset.

Decomposition:
- Shared package game_pkg: player state enum (IDLE, SETUP, ENTER, WAIT, EVAL, DONE), GUESS_WIDTH=8, ATTEMPT_WIDTH=4.
- One natural sub-module: game_search_range, which holds the lo/hi registers, the mid calculation and the empty (lo>hi) flag, with narrow/init controls from the FSM.

Test Plan:
- Model secret=127, start -> one enter with guess 127, equal -> DONE, found=1, num_guesses=1, error=0.
- Model secret=200 -> guesses 127,191,223,207,199,203,201,200 in that order, found=1, num_guesses=8.
- Model secret=0 -> guesses 127,63,31,15,7,3,1,0, found=1, num_guesses=8.
- Model always under -> guesses 127,191,223,239,247,251,253,254,255, then lo=256>hi -> DONE, error=1, found=0.
- Model secret=5 with remaining attempts 2,1,0 -> after the third update: DONE, found=0, error=0, num_guesses=3.
- Reset asserted during WAIT after guess 127 -> next cycle all outputs at reset values; a new start restarts from guess 127. With the macro defined and no update pulse -> error=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the number-guessing auto player.
package game_pkg;
  localparam int GUESS_WIDTH   = 8;
  localparam int ATTEMPT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENTER,
    WAIT,
    EVAL,
    DONE
  } player_state_t;
endpackage

// File: rtl/game_search_range.sv
// Binary-search window: lo/hi registers, midpoint, and emptiness of the
// window that the current narrow/init controls would produce.
module game_search_range
  import game_pkg::*;
#(
  parameter int WIDTH = GUESS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_init,
  input  logic             i_up,
  input  logic             i_dn,
  output logic [WIDTH-1:0] o_mid,
  output logic [WIDTH-1:0] o_mid_nxt,
  output logic             o_empty_nxt
);
  localparam logic [WIDTH:0] MAXV = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] r_lo, r_hi;
  logic [WIDTH:0] w_lo_nxt, w_hi_nxt;
  logic [WIDTH:0] w_sum, w_mid, w_sum_nxt;

  // lo never exceeds 2^WIDTH and hi never exceeds 2^WIDTH-1, so the sum fits
  assign w_sum = r_lo + r_hi;
  assign w_mid = w_sum >> 1;
  assign o_mid = WIDTH'(w_mid);

  always_comb begin
    w_lo_nxt = r_lo;
    w_hi_nxt = r_hi;
    if (i_init) begin
      w_lo_nxt = '0;
      w_hi_nxt = MAXV;
    end else if (i_up) begin
      w_lo_nxt = w_mid + ONE;
    end else if (i_dn) begin
      w_hi_nxt = w_mid - ONE;
    end
  end

  assign w_sum_nxt = w_lo_nxt + w_hi_nxt;
  assign o_mid_nxt = WIDTH'(w_sum_nxt >> 1);

  // hi only sets its top bit when it wrapped to -1; lo's top bit means 2^WIDTH
  assign o_empty_nxt = $signed({1'b0, w_lo_nxt}) > $signed({w_hi_nxt[WIDTH], w_hi_nxt});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo <= '0;
      r_hi <= MAXV;
    end else begin
      r_lo <= w_lo_nxt;
      r_hi <= w_hi_nxt;
    end
  end
endmodule

// File: rtl/game_auto_player.sv
// Automatic binary-search player driving the guessing-game responder.
// Optional wait timeout enabled by defining GAME_AUTO_PLAYER_TIMEOUT_EN.
module game_auto_player
  import game_pkg::*;
#(
  parameter int WIDTH          = GUESS_WIDTH,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic [WIDTH-1:0]         o_guess,
  output logic                     o_enter,
  input  logic                     i_under,
  input  logic                     i_over,
  input  logic                     i_equal,
  input  logic                     i_update_leds,
  input  logic [ATTEMPT_WIDTH-1:0] i_remaining_attempts,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_found,
  output logic                     o_error,
  output logic [ATTEMPT_WIDTH-1:0] o_num_guesses
);
  player_state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]         r_guess;
  logic [ATTEMPT_WIDTH-1:0] r_num;
  logic [ATTEMPT_WIDTH-1:0] r_rem;
  logic [15:0]              r_settle;
  logic                     r_found, r_error;
  logic                     r_under, r_over, r_equal;

  logic             w_init, w_up, w_dn;
  logic             w_set_found, w_set_err, w_enter_setup, w_settle_done, w_timeout;
  logic [WIDTH-1:0] w_mid, w_mid_nxt;
  logic             w_empty_nxt;

  game_search_range #(.WIDTH(WIDTH)) u_range (
    .clk        (clk),
    .reset      (reset),
    .i_init     (w_init),
    .i_up       (w_up),
    .i_dn       (w_dn),
    .o_mid      (w_mid),
    .o_mid_nxt  (w_mid_nxt),
    .o_empty_nxt(w_empty_nxt)
  );

`ifdef GAME_AUTO_PLAYER_TIMEOUT_EN
  logic [7:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset || r_state == ENTER) r_wait <= '0;
    else if (r_state == WAIT && r_wait != 8'(TIMEOUT_CYCLES)) r_wait <= r_wait + 8'd1;
  end

  assign w_timeout = (r_state == WAIT) && (r_wait == 8'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_settle_done = (r_settle == 16'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_up        = 1'b0;
    w_dn        = 1'b0;
    w_set_found = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_nxt = SETUP;
          w_init      = 1'b1;
        end
      end
      SETUP: if (w_settle_done) w_state_nxt = ENTER;
      ENTER: w_state_nxt = WAIT;
      WAIT: begin
        if (i_update_leds) begin
          w_state_nxt = EVAL;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_set_err   = 1'b1;
        end
      end
      EVAL: begin
        if (r_equal) begin
          w_state_nxt = DONE;
          w_set_found = 1'b1;
        end else if (r_under == r_over) begin
          w_state_nxt = DONE;
          w_set_err   = 1'b1;
        end else if (r_rem == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_up = r_under;
          w_dn = r_over;
          if (w_empty_nxt) begin
            w_state_nxt = DONE;
            w_set_err   = 1'b1;
          end else begin
            w_state_nxt = SETUP;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_setup = (w_state_nxt == SETUP) && (r_state != SETUP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_guess  <= '0;
      r_num    <= '0;
      r_rem    <= '0;
      r_settle <= '0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
      r_under  <= 1'b0;
      r_over   <= 1'b0;
      r_equal  <= 1'b0;
    end else begin
      // guess comes from the window being loaded, so it is stable for all of SETUP
      if (w_enter_setup) begin
        r_guess  <= w_mid_nxt;
        r_settle <= '0;
      end else if (r_state == SETUP) begin
        r_settle <= r_settle + 16'd1;
      end
      if (w_init) begin
        r_num   <= '0;
        r_found <= 1'b0;
        r_error <= 1'b0;
      end
      if (r_state == ENTER && r_num != '1) r_num <= r_num + ATTEMPT_WIDTH'(1);
      if (r_state == WAIT && i_update_leds) begin
        r_under <= i_under;
        r_over  <= i_over;
        r_equal <= i_equal;
        r_rem   <= i_remaining_attempts;
      end
      if (w_set_found) r_found <= 1'b1;
      if (w_set_err)   r_error <= 1'b1;
    end
  end

  assign o_guess       = r_guess;
  assign o_enter       = (r_state == ENTER);
  assign o_busy        = (r_state != IDLE) && (r_state != DONE);
  assign o_done        = (r_state == DONE);
  assign o_found       = r_found;
  assign o_error       = r_error;
  assign o_num_guesses = r_num;

  // w_mid is the guess being evaluated; kept visible for debug probing
  logic w_mid_matches;
  assign w_mid_matches = (w_mid == r_guess);
  logic unused_ok;
  assign unused_ok = w_mid_matches;
endmodule

// File: tb/tb_game_auto_player.sv
// Directed bench: a responder model answers enters, a search model predicts
// the guess sequence and outcome, literal vectors pin the known cases.
module tb_game_auto_player;
  logic       clk, reset, i_start;
  logic [7:0] o_guess;
  logic       o_enter, i_under, i_over, i_equal, i_update_leds;
  logic [3:0] i_remaining_attempts, o_num_guesses;
  logic       o_busy, o_done, o_found, o_error;

  game_auto_player dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_guess(o_guess), .o_enter(o_enter),
    .i_under(i_under), .i_over(i_over), .i_equal(i_equal),
    .i_update_leds(i_update_leds), .i_remaining_attempts(i_remaining_attempts),
    .o_busy(o_busy), .o_done(o_done), .o_found(o_found), .o_error(o_error),
    .o_num_guesses(o_num_guesses)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0, n_fail = 0;
  int exp_q[$];
  int seen[$];
  int cnt = 0;
  int mode = 0, secret = 0, attempts = 15, nresp = 0;
  bit resp_en = 1;
  bit pend = 0;
  int pend_g = 0;
  int m_found, m_err, m_n;

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Plain integer binary search following the game's rules
  task automatic build_expect(input int md, input int sec, input int att);
    int lo, hi, mid, n, rem;
    lo = 0; hi = 255; n = 0;
    exp_q.delete();
    m_found = 0; m_err = 0;
    forever begin
      mid = (lo + hi) / 2;
      exp_q.push_back(mid);
      n++;
      rem = (att > n) ? att - n : 0;
      if (md == 0 && mid == sec) begin m_found = 1; break; end
      if (rem == 0) break;
      if (md == 1 || mid < sec) lo = mid + 1; else hi = mid - 1;
      if (lo > hi) begin m_err = 1; break; end
    end
    m_n = (n > 15) ? 15 : n;
  endtask

  // Responder: answers each enter one cycle later
  initial begin
    i_update_leds = 0; i_under = 0; i_over = 0; i_equal = 0; i_remaining_attempts = 0;
    forever begin
      @(posedge clk); #1;
      i_update_leds = 0; i_under = 0; i_over = 0; i_equal = 0;
      if (reset) pend = 0;
      if (pend) begin
        pend = 0;
        nresp++;
        i_update_leds = 1;
        if (mode == 1) i_under = 1;
        else begin
          i_under = (pend_g < secret);
          i_over  = (pend_g > secret);
          i_equal = (pend_g == secret);
        end
        i_remaining_attempts = 4'((attempts > nresp) ? attempts - nresp : 0);
      end
      if (o_enter && resp_en && !reset) begin
        pend = 1;
        pend_g = o_guess;
      end
    end
  end

  // Compare process: guess on every enter, guess count while busy
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset && o_busy) check("num_guesses", o_num_guesses, cnt);
      if (o_enter) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_enter: got guess %0d, expected no enter", o_guess);
        end else begin
          check("guess", o_guess, exp_q.pop_front());
        end
        seen.push_back(int'(o_guess));
        cnt = (cnt < 15) ? cnt + 1 : 15;
      end
    end
  end

  task automatic pulse_start();
    seen.delete();
    cnt = 0; nresp = 0;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int k = 0;
    while (!o_done && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    if (!o_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected done=1", nm, bound);
    end
  endtask

  task automatic run_search(input string nm, input int md, input int sec, input int att,
                            input int lf, input int le, input int ln);
    mode = md; secret = sec; attempts = att; resp_en = 1;
    build_expect(md, sec, att);
    pulse_start();
    wait_done(nm, 300);
    check({nm, "_found"}, o_found, m_found);
    check({nm, "_error"}, o_error, m_err);
    check({nm, "_num"}, o_num_guesses, m_n);
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_found_lit"}, o_found, lf);
    check({nm, "_error_lit"}, o_error, le);
    check({nm, "_num_lit"}, o_num_guesses, ln);
    check({nm, "_busy"}, o_busy, 0);
  endtask

  task automatic check_seq(input string nm, input int e[$]);
    check({nm, "_len"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++) check(nm, seen[i], e[i]);
  endtask

  initial begin
    int lit[$];
    reset = 1; i_start = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_guess", o_guess, 0);
    check("rst_enter", o_enter, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_found", o_found, 0);
    check("rst_error", o_error, 0);
    check("rst_num", o_num_guesses, 0);
    reset = 0;
    @(posedge clk); #1;

    run_search("s127", 0, 127, 15, 1, 0, 1);
    lit = '{127};
    check_seq("s127_seq", lit);

    run_search("s200", 0, 200, 15, 1, 0, 8);
    lit = '{127, 191, 223, 207, 199, 203, 201, 200};
    check_seq("s200_seq", lit);

    run_search("s0", 0, 0, 15, 1, 0, 8);
    lit = '{127, 63, 31, 15, 7, 3, 1, 0};
    check_seq("s0_seq", lit);

    run_search("under", 1, 0, 15, 0, 1, 9);
    lit = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    check_seq("under_seq", lit);

    run_search("att", 0, 5, 3, 0, 0, 3);
    lit = '{127, 63, 31};
    check_seq("att_seq", lit);

    // Start while busy must be ignored
    mode = 0; secret = 255; attempts = 15; resp_en = 1;
    build_expect(0, 255, 15);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    wait_done("busy_start", 300);
    check("busy_start_found", o_found, 1);
    check("busy_start_num", o_num_guesses, m_n);

    // Reset while waiting for feedback on the first guess
    resp_en = 0;
    exp_q.delete();
    exp_q.push_back(127);
    pulse_start();
    begin
      int k = 0;
      while (!o_enter && k < 20) begin @(posedge clk); #1; k++; end
      check("rst_mid_enter_seen", o_enter, 1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    check("rstw_guess", o_guess, 0);
    check("rstw_enter", o_enter, 0);
    check("rstw_busy", o_busy, 0);
    check("rstw_done", o_done, 0);
    check("rstw_found", o_found, 0);
    check("rstw_error", o_error, 0);
    check("rstw_num", o_num_guesses, 0);
    reset = 0;
    begin
      int enters = 0;
      repeat (5) begin @(posedge clk); #1; if (o_enter) enters++; end
      check("rstw_no_enter", enters, 0);
    end
    run_search("after_rst", 0, 5, 15, 1, 0, 7);
    check("after_rst_first", seen.size() > 0 ? seen[0] : -1, 127);

`ifdef GAME_AUTO_PLAYER_TIMEOUT_EN
    resp_en = 0;
    exp_q.delete();
    exp_q.push_back(127);
    pulse_start();
    wait_done("tmo", 400);
    check("tmo_error", o_error, 1);
    check("tmo_found", o_found, 0);
    check("tmo_num", o_num_guesses, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
